serial_word_receiver: RTL and testbench
=======================================

Name: serial_word_receiver

Overview:
Downstream counterpart of the team's parallel-to-serial shifter. It takes a bit-strobed serial stream (optionally differential), assembles WIDTH-bit words in the configured bit order, and presents each word on a registered parallel output with a valid/ready handshake. It detects overrun, differential-pair faults and (optionally) parity errors, and resynchronises on a start marker.

Parameters:
WIDTH, 8, data word width in bits (>= 2)
LSB, 0, bit order: 0 = MSB received first, 1 = LSB received first
DIFFERENTIAL, 0, 1 = qualify every received bit with sin_neg == !sin

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
sin  input  1  serial data bit
sin_neg  input  1  complementary serial bit; ignored when DIFFERENTIAL=0
sin_valid  input  1  bit strobe; sin is sampled on edges where sin_valid=1
sin_start  input  1  marks the current strobed bit as bit 0 of a new word
data  output  WIDTH  assembled word (registered)
data_valid  output  1  data holds an undelivered word
data_ready  input  1  consumer accepts data on edges where data_valid && data_ready
overrun  output  1  one-cycle pulse: completed word dropped because output slot occupied
diff_err  output  1  one-cycle pulse: differential fault, partial word discarded
parity_err  output  1  one-cycle pulse: parity mismatch (see optional feature)

Behaviour:
- Reset (synchronous, active-high, on clk; clock is clk): data=0, data_valid=0, overrun=0, diff_err=0, parity_err=0, state=IDLE, bit count=0, shift register=0. A reset mid-word or with a word held discards everything.
- Bit count register width is $clog2(WIDTH+1).
- States: IDLE, SHIFT, PARITY (PARITY only reachable when the optional feature is compiled in).
- IDLE: sin_valid && sin_start -> capture bit, count=1, go to SHIFT. sin_valid without sin_start is ignored.
- SHIFT: each sin_valid captures one bit and increments count.
  - LSB=0: sreg <= {sreg[WIDTH-2:0], sin}.
  - LSB=1: sreg <= {sin, sreg[WIDTH-1:1]}.
- sin_valid && sin_start in SHIFT or PARITY: partial word silently discarded, bit taken as bit 0 of a new word, count=1. No error flag.
- Word completion is the edge capturing bit WIDTH (or the parity bit when the feature is enabled). On that same edge:
  - If the slot is free (data_valid=0, or data_ready=1 on that edge): data <= word and data_valid <= 1. data_valid is visible in the cycle after the last bit strobe (latency 1).
  - Else: word dropped, data unchanged, overrun=1 for one cycle.
  - State returns to IDLE, count=0.
- Handshake: transfer on any edge with data_valid && data_ready. data_valid clears on the next cycle unless a new word completes on the same edge; back-to-back words therefore keep data_valid high with no bubble. data is stable while data_valid=1 && data_ready=0.
- DIFFERENTIAL=1: a strobed bit with sin_neg == sin is invalid.
  - Pulse diff_err for one cycle, discard the partial word, go to IDLE.
  - This applies even if the bad bit carries sin_start (no new word started).
  - The held output word is unaffected.
- Error pulses (overrun, diff_err, parity_err) are registered, high exactly one cycle per event. Any combination may assert in the same cycle.
- sin_valid is ignored in the cycle reset is high.

Optional Feature:
Macro SERIAL_WORD_RECEIVER_PARITY_EN.
- Defined: after the WIDTH data bits, the state machine enters PARITY and waits for one more sin_valid carrying an even-parity bit (expected = XOR of the data bits). Match -> word completes as above. Mismatch -> word dropped, parity_err pulses one cycle, no overrun is flagged, go to IDLE.
- Not defined: no PARITY state; the word completes on bit WIDTH; parity_err is tied to 0. The port list is identical in both builds.

Test Plan:
1. WIDTH=8, LSB=0, data_ready=1; send bits 1,0,1,0,0,1,0,1 (start on first) -> data=0xA5, data_valid high for exactly 1 cycle, starting the cycle after the 8th strobe.
2. LSB=1; send bits 0,0,0,1,1,1,1,0 -> data=0x78. Then send two words with no gap between bit strobes -> data_valid stays high across both with no bubble.
3. data_ready=0; send 0x11 then 0x22 -> data stays 0x11, overrun pulses 1 cycle at completion of 0x22; raise data_ready -> data_valid drops the next cycle.
4. Send 3 bits, then sin_start with 0xC3 -> only 0xC3 delivered, no error flags. Assert reset mid-word and with a word held -> all outputs 0, no later delivery.
5. DIFFERENTIAL=1; drive sin_neg==sin on the 4th bit -> diff_err pulse, no data_valid; next word 0x5A with correct sin_neg -> delivered.
6. SERIAL_WORD_RECEIVER_PARITY_EN defined; 0x07 with parity bit 1 -> delivered; 0x07 with parity bit 0 -> parity_err pulse, data_valid stays 0.

Source files
------------

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver with start-marker resync, valid/ready output slot,
// and overrun, differential-fault and optional parity error pulses.
// Optional even-parity bit after each word: define SERIAL_WORD_RECEIVER_PARITY_EN.
//
// state  | meaning
// IDLE   | waiting for a strobed bit carrying sin_start
// SHIFT  | collecting data bits, count = bits captured so far
// PARITY | all data bits in, waiting for the parity bit (parity build only)
module serial_word_receiver #(
    parameter int WIDTH        = 8,
    parameter int LSB          = 0,
    parameter int DIFFERENTIAL = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sin,
    input  logic             sin_neg,
    input  logic             sin_valid,
    input  logic             sin_start,
    output logic [WIDTH-1:0] data,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             overrun,
    output logic             diff_err,
    output logic             parity_err
);

    localparam int CW = $clog2(WIDTH + 1);

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
    assign parity_err = 1'b0;
`endif

    state_t           state;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic [WIDTH-1:0] first_word;
    logic             bit_ok;
    logic             slot_free;

    // sreg_next folds the current bit into the partial word; first_word starts a fresh one
    always_comb begin
        sreg_next  = '0;
        first_word = '0;
        if (LSB != 0) begin
            sreg_next  = {sin, sreg[WIDTH-1:1]};
            first_word = {sin, {(WIDTH-1){1'b0}}};
        end else begin
            sreg_next  = {sreg[WIDTH-2:0], sin};
            first_word = {{(WIDTH-1){1'b0}}, sin};
        end
    end

    assign bit_ok    = (DIFFERENTIAL == 0) || (sin_neg != sin);
    assign slot_free = !data_valid || data_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            sreg       <= '0;
            data       <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            diff_err   <= 1'b0;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun  <= 1'b0;
            diff_err <= 1'b0;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
            parity_err <= 1'b0;
`endif
            // a word completing below overrides this clear, so back-to-back words have no bubble
            if (data_valid && data_ready)
                data_valid <= 1'b0;

            if (sin_valid) begin
                if (!bit_ok) begin
                    diff_err <= 1'b1;
                    state    <= IDLE;
                    count    <= '0;
                    sreg     <= '0;
                end else if (sin_start) begin
                    sreg  <= first_word;
                    count <= CW'(1);
                    state <= SHIFT;
                end else begin
                    case (state)
                        SHIFT: begin
                            sreg  <= sreg_next;
                            count <= count + CW'(1);
                            if (count == CW'(WIDTH - 1)) begin
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
                                state <= PARITY;
`else
                                if (slot_free) begin
                                    data       <= sreg_next;
                                    data_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                                state <= IDLE;
                                count <= '0;
`endif
                            end
                        end
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
                        PARITY: begin
                            if (sin == ^sreg) begin
                                if (slot_free) begin
                                    data       <= sreg;
                                    data_valid <= 1'b1;
                                end else begin
                                    overrun <= 1'b1;
                                end
                            end else begin
                                parity_err <= 1'b1;
                            end
                            state <= IDLE;
                            count <= '0;
                        end
`endif
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Bench for serial_word_receiver: three instances (MSB-first, LSB-first, differential MSB-first)
// share one stimulus stream; each has its own expected-word queue drained by a monitor.
module tb_serial_word_receiver;

    logic       clk = 1'b0;
    logic       reset, sin, sin_neg, sin_valid, sin_start, data_ready;
    logic [7:0] dout [3];
    logic       dv [3];
    logic       ovr [3];
    logic       de [3];
    logic       pe [3];

    int passed = 0;
    int total  = 0;
    int n_ovr [3] = '{0, 0, 0};
    int n_de  [3] = '{0, 0, 0};
    int n_pe  [3] = '{0, 0, 0};

    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    logic [7:0] q2 [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        serial_word_receiver #(
            .WIDTH(8),
            .LSB((g == 1) ? 1 : 0),
            .DIFFERENTIAL((g == 2) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .reset     (reset),
            .sin       (sin),
            .sin_neg   (sin_neg),
            .sin_valid (sin_valid),
            .sin_start (sin_start),
            .data      (dout[g]),
            .data_valid(dv[g]),
            .data_ready(data_ready),
            .overrun   (ovr[g]),
            .diff_err  (de[g]),
            .parity_err(pe[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic pop_cmp(input int i);
        int         sz;
        logic [7:0] e;
        case (i)
            0:       sz = q0.size();
            1:       sz = q1.size();
            default: sz = q2.size();
        endcase
        if (sz == 0) begin
            total++;
            $display("FAIL unexpected_word dut%0d: got 0x%0h, want none", i, dout[i]);
        end else begin
            case (i)
                0:       e = q0.pop_front();
                1:       e = q1.pop_front();
                default: e = q2.pop_front();
            endcase
            chk($sformatf("word_dut%0d", i), dout[i], e);
        end
    endtask

    // monitor: a word is consumed on the coming edge whenever valid && ready
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            for (int i = 0; i < 3; i++) begin
                if (ovr[i]) n_ovr[i]++;
                if (de[i])  n_de[i]++;
                if (pe[i])  n_pe[i]++;
                if (dv[i] && data_ready) pop_cmp(i);
            end
        end
    end

    task automatic push(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
        q0.push_back(e0);
        q1.push_back(e1);
        q2.push_back(e2);
    endtask

    task automatic strobe(input logic b, input logic st, input logic bad);
        sin       = b;
        sin_neg   = bad ? b : ~b;
        sin_start = st;
        sin_valid = 1'b1;
        @(posedge clk); #1;
        sin_valid = 1'b0;
        sin_start = 1'b0;
    endtask

    // MSB of w goes out first; bad_idx marks the bit sent with sin_neg == sin
    task automatic send_word(input logic [7:0] w, input int bad_idx, input bit ready_last,
                             input bit par_flip);
        for (int k = 0; k < 8; k++) begin
`ifndef SERIAL_WORD_RECEIVER_PARITY_EN
            if (k == 7 && ready_last) data_ready = 1'b1;
`endif
            strobe(w[7-k], k == 0, k == bad_idx);
        end
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        if (ready_last) data_ready = 1'b1;
        strobe((^w) ^ par_flip, 1'b0, 1'b0);
`else
        if (par_flip) data_ready = data_ready;
`endif
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; sin = 1'b0; sin_neg = 1'b1; sin_valid = 1'b0; sin_start = 1'b0;
        data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_data_dut%0d", i), dout[i], 0);
            chk($sformatf("reset_valid_dut%0d", i), dv[i], 0);
            chk($sformatf("reset_flags_dut%0d", i), {ovr[i], de[i], pe[i]}, 0);
        end

        // single word, latency 1, valid for exactly one cycle
        push(8'hA5, 8'hA5, 8'hA5);
        send_word(8'hA5, -1, 0, 0);
        chk("t1_valid_after_last", dv[0], 1);
        chk("t1_data", dout[0], 8'hA5);
        idle(1);
        chk("t1_valid_one_cycle", dv[0], 0);

        push(8'h1E, 8'h78, 8'h1E);
        send_word(8'h1E, -1, 0, 0);
        idle(2);

        // held word handed off on the same edge the next word completes
        data_ready = 1'b0;
        push(8'h3C, 8'h3C, 8'h3C);
        send_word(8'h3C, -1, 0, 0);
        chk("t2_hold_valid", dv[1], 1);
        push(8'h96, 8'h69, 8'h96);
        send_word(8'h96, -1, 1, 0);
        chk("t2_no_bubble_valid", dv[1], 1);
        chk("t2_no_bubble_data0", dout[0], 8'h96);
        chk("t2_no_bubble_data1", dout[1], 8'h69);
        idle(2);

        // overrun while the slot is held
        data_ready = 1'b0;
        push(8'h11, 8'h88, 8'h11);
        send_word(8'h11, -1, 0, 0);
        send_word(8'h22, -1, 0, 0);
        idle(2);
        chk("t3_data_held0", dout[0], 8'h11);
        chk("t3_data_held1", dout[1], 8'h88);
        chk("t3_valid_held", dv[0], 1);
        for (int i = 0; i < 3; i++) chk($sformatf("t3_overrun_dut%0d", i), n_ovr[i], 1);
        data_ready = 1'b1;
        idle(1);
        chk("t3_valid_drop", dv[0], 0);

        // restart on start marker mid-word
        strobe(1'b1, 1'b1, 1'b0);
        strobe(1'b0, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        push(8'hC3, 8'hC3, 8'hC3);
        send_word(8'hC3, -1, 0, 0);
        idle(2);
        chk("t4_no_new_overrun", n_ovr[0] + n_ovr[1] + n_ovr[2], 3);
        chk("t4_no_diff_err", n_de[0] + n_de[1] + n_de[2], 0);

        // reset mid-word: trailing bits without a start marker are ignored
        strobe(1'b1, 1'b1, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) strobe(1'b1, 1'b0, 1'b0);
        idle(2);
        chk("t4_rst_mid_valid", dv[0], 0);

        // reset with a word held discards it
        data_ready = 1'b0;
        send_word(8'h5A, -1, 0, 0);
        chk("t4_held_before_reset", dv[2], 1);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("t4_rst_data_dut%0d", i), dout[i], 0);
            chk($sformatf("t4_rst_valid_dut%0d", i), dv[i], 0);
        end
        data_ready = 1'b1;
        idle(3);

        // differential fault on the 4th bit
        q0.push_back(8'hF0);
        q1.push_back(8'h0F);
        send_word(8'hF0, 3, 0, 0);
        idle(2);
        chk("t5_diff_err_dut2", n_de[2], 1);
        chk("t5_diff_err_dut0", n_de[0], 0);
        chk("t5_no_valid_dut2", dv[2], 0);
        push(8'h5A, 8'h5A, 8'h5A);
        send_word(8'h5A, -1, 0, 0);
        idle(2);
        // bad bit that also carries the start marker must not begin a word
        q0.push_back(8'hFF);
        q1.push_back(8'hFF);
        send_word(8'hFF, 0, 0, 0);
        idle(2);
        chk("t5_diff_err_start", n_de[2], 2);

`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
        push(8'h07, 8'hE0, 8'h07);
        send_word(8'h07, -1, 0, 0);
        idle(2);
        send_word(8'h07, -1, 0, 1);
        chk("t6_parity_no_valid", dv[0], 0);
        idle(2);
        for (int i = 0; i < 3; i++) chk($sformatf("t6_parity_err_dut%0d", i), n_pe[i], 1);
        chk("t6_no_overrun", n_ovr[0], 1);
`endif

        idle(3);
        chk("end_queue_dut0", q0.size(), 0);
        chk("end_queue_dut1", q1.size(), 0);
        chk("end_queue_dut2", q2.size(), 0);
        chk("end_parity_total", n_pe[0] + n_pe[1] + n_pe[2],
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
            3
`else
            0
`endif
        );

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
